// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the CPU pipeline stage registers.
//   - pipe_state_t : occupancy state of a pipe_stage_reg (EMPTY / FULL / SKID)
//   - DEFAULT_CNT_W: default width of the per-stage stall counter
//   - *_W          : payload widths of the inter-stage registers
//
// SKID is only reachable when PIPE_STAGE_SKID_EN is defined. The encoding is
// shared by both builds.
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    localparam int unsigned DEFAULT_CNT_W = 16;

    // IF/ID packs {instr, pc4}; the later stages carry decoded control plus
    // operands and results.
    localparam int unsigned IF_ID_W   = 64;
    localparam int unsigned ID_EX_W   = 160;
    localparam int unsigned EX_MEM_W  = 112;
    localparam int unsigned MEM_WB_W  = 72;

endpackage

// File: rtl/pipe_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_skid_slot
//
// One storage slot of a pipeline stage: a WIDTH-bit payload plus a valid bit.
// The same module is used for the main slot and for the optional skid slot.
//
// Parameters:
//   WIDTH   payload width
//   BUBBLE  payload value held while the slot is empty
//
// Ports:
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-high reset (slot -> BUBBLE, invalid)
//   clear      in   synchronous clear to BUBBLE / invalid (wins over load)
//   load       in   capture load_data and mark the slot valid
//   load_data  in   payload to capture
//   data       out  registered payload
//   valid      out  registered valid bit
// -----------------------------------------------------------------------------
module pipe_skid_slot #(
    parameter int unsigned      WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else if (clear) begin
            data_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            valid_q <= 1'b1;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline stage register with valid/ready handshake, synchronous
// flush to a bubble and a saturating stall counter. Sits between every pair of
// CPU pipeline stages.
//
// Build option (macro PIPE_STAGE_SKID_EN):
//   defined   - adds a skid slot and the SKID state; in_ready comes straight
//               from the state register, with no path from out_ready.
//   undefined - single slot; in_ready = !out_valid || out_ready (combinational).
// The port list is identical in both builds.
//
// Parameters:
//   WIDTH   payload width
//   BUBBLE  payload shown while empty, after flush and after reset
//   CNT_W   stall counter width
//
// Ports:
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-high reset
//   flush      in   synchronous squash of all held entries
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage accepts this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data is live (registered)
//   out_ready  in   downstream accepts this cycle
//   out_data   out  registered payload
//   stall_cnt  out  cycles with out_valid && !out_ready, saturating
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = IF_ID_W,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W  = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t state_q, state_d;

    logic             in_fire;
    logic             out_fire;

    logic             main_load;
    logic             main_clear;
    logic [WIDTH-1:0] main_load_data;
    logic [WIDTH-1:0] main_data;
    logic             main_valid;

    logic [CNT_W-1:0] stall_q, stall_d;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_load;
    logic             skid_clear;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
`endif

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
`ifdef PIPE_STAGE_SKID_EN
    // Registered ready: only the SKID state refuses input.
    assign in_ready = (state_q != SKID);
`else
    assign in_ready = !main_valid || out_ready;
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // -------------------------------------------------------------------------
    // Next-state and slot control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_load_data = in_data;
`ifdef PIPE_STAGE_SKID_EN
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
`endif

        if (flush) begin
            // Anything offered this cycle is dropped, even if in_ready is high.
            state_d    = EMPTY;
            main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = FULL;
                        main_load = 1'b1;
                    end
                end

                FULL: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    // in_fire with a stalled output: park the new entry.
                    else if (in_fire) begin
                        state_d   = SKID;
                        skid_load = 1'b1;
                    end
`endif
                end

`ifdef PIPE_STAGE_SKID_EN
                SKID: begin
                    if (out_fire) begin
                        state_d        = FULL;
                        main_load      = 1'b1;
                        main_load_data = skid_data;
                        skid_clear     = 1'b1;
                    end
                end
`endif

                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage slots
    // -------------------------------------------------------------------------
    pipe_skid_slot #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_main_slot (
        .clk       (clk),
        .clr       (clr),
        .clear     (main_clear),
        .load      (main_load),
        .load_data (main_load_data),
        .data      (main_data),
        .valid     (main_valid)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_slot #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_skid_slot (
        .clk       (clk),
        .clr       (clr),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_data (in_data),
        .data      (skid_data),
        .valid     (skid_valid)
    );

    // The skid valid bit mirrors state_q == SKID; it must never be set
    // while the stage claims it can accept input.
    always_ff @(posedge clk) begin
        if (!clr) begin
            assert (!(skid_valid && in_ready))
                else $error("skid slot occupied while in_ready is high");
        end
    end
`endif

    assign out_valid = main_valid;
    assign out_data  = main_data;

    // -------------------------------------------------------------------------
    // Saturating stall counter (flush does not touch it)
    // -------------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (WIDTH=16, BUBBLE=0, CNT_W=4).
// Works for both builds; build-specific sequences are selected by
// PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    logic        clk;
    logic        clr;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    pipe_stage_reg #(
        .WIDTH  (16),
        .BUBBLE (16'h0000),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Drive inputs just after an edge and let combinational outputs settle.
    task automatic drive(input logic iv, input logic [15:0] d, input logic ordy,
                         input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1 clr = 1'b1;
        #2;
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_ready", in_ready, 1);
        tick();
        clr = 1'b0;

        // Streaming 1..8 with out_ready held high.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 16'(k), 1'b1, 1'b0);
            chk("stream_ready", in_ready, 1);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, k);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_data", out_data, 0);
        chk("stream_stall", stall_cnt, 0);

        // Back-pressure: out_ready low for 3 cycles while offering A, B, C.
        drive(1'b1, 16'h000A, 1'b1, 1'b0);
        tick();
        chk("bp_a_loaded", out_data, 16'h000A);
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        chk("bp_ready_full", in_ready, 1);
        tick();
        drive(1'b1, 16'h000C, 1'b0, 1'b0);
        chk("bp_ready_skid", in_ready, 0);
        tick();
        tick();
        chk("bp_hold_a", out_data, 16'h000A);
        chk("bp_stall3", stall_cnt, 3);
        chk("bp_ready_hold", in_ready, 0);
        drive(1'b1, 16'h000C, 1'b1, 1'b0);
        chk("bp_ready_reg", in_ready, 0);
        tick();
        chk("bp_rel_b", out_data, 16'h000B);
        drive(1'b1, 16'h000C, 1'b1, 1'b0);
        chk("bp_ready_back", in_ready, 1);
        tick();
        chk("bp_rel_c", out_data, 16'h000C);
`else
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        chk("bp_ready_low", in_ready, 0);
        tick();
        tick();
        tick();
        chk("bp_hold_a", out_data, 16'h000A);
        chk("bp_stall3", stall_cnt, 3);
        drive(1'b1, 16'h000B, 1'b1, 1'b0);
        chk("bp_ready_rel", in_ready, 1);
        tick();
        chk("bp_rel_b", out_data, 16'h000B);
        drive(1'b1, 16'h000C, 1'b1, 1'b0);
        tick();
        chk("bp_rel_c", out_data, 16'h000C);
`endif
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("bp_empty", out_valid, 0);
        chk("bp_stall_kept", stall_cnt, 3);

        // Saturation: 20 stalled cycles on top of 3 -> stops at 15.
        drive(1'b1, 16'h0005, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        chk("sat_14", stall_cnt, 14);
        for (int i = 0; i < 9; i++) tick();
        chk("sat_15", stall_cnt, 15);
        chk("sat_hold_data", out_data, 16'h0005);

        // Flush while FULL with a live offer that would otherwise be accepted.
        drive(1'b1, 16'hDEAD, 1'b1, 1'b1);
        chk("flush_ready", in_ready, 1);
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_data", out_data, 0);
        chk("flush_stall", stall_cnt, 15);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("flush_no_dead_v", out_valid, 0);
        chk("flush_no_dead_d", out_data, 0);

        // Asynchronous reset mid-stream with entries held.
        drive(1'b1, 16'h0011, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h0022, 1'b0, 1'b0);
        tick();
        chk("pre_clr_data", out_data, 16'h0011);
        #2 clr = 1'b1;
        #1;
        chk("clr_valid", out_valid, 0);
        chk("clr_data", out_data, 0);
        chk("clr_stall", stall_cnt, 0);
        chk("clr_ready", in_ready, 1);
        tick();
        clr = 1'b0;
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("post_clr_valid", out_valid, 0);
        drive(1'b1, 16'h0033, 1'b1, 1'b0);
        tick();
        chk("post_clr_data", out_data, 16'h0033);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("post_clr_empty", out_valid, 0);
        chk("post_clr_bubble", out_data, 0);
        chk("post_clr_stall", stall_cnt, 0);

`ifndef PIPE_STAGE_SKID_EN
        // Combinational ready follows out_ready while toggling.
        drive(1'b1, 16'h0041, 1'b0, 1'b0);
        chk("tog_ready_empty", in_ready, 1);
        tick();
        chk("tog_d41", out_data, 16'h0041);
        drive(1'b1, 16'h0042, 1'b0, 1'b0);
        chk("tog_ready_stall", in_ready, 0);
        tick();
        chk("tog_hold41", out_data, 16'h0041);
        drive(1'b1, 16'h0042, 1'b1, 1'b0);
        chk("tog_ready_go", in_ready, 1);
        tick();
        chk("tog_d42", out_data, 16'h0042);
        drive(1'b1, 16'h0043, 1'b0, 1'b0);
        chk("tog_ready_stall2", in_ready, 0);
        tick();
        chk("tog_hold42", out_data, 16'h0042);
        drive(1'b1, 16'h0043, 1'b1, 1'b0);
        chk("tog_ready_go2", in_ready, 1);
        tick();
        chk("tog_d43", out_data, 16'h0043);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("tog_empty", out_valid, 0);
        chk("tog_stall", stall_cnt, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
